// File: rtl/proc_fetch_unit_if.sv
// proc_fetch_unit_if
//   Bundles the fetch unit's two handshakes: the program-memory request /
//   response channel and the instruction hand-off to decode.
//   master : the fetch unit (drives imem_req/imem_add and the inst_* head)
//   slave  : the environment (memory + decode + redirect source)
//   Signals:
//     fetch_en, redir, redir_pc           control from the core
//     imem_req, imem_add                  fetch request and word address
//     imem_gnt, imem_rvalid, imem_rdata   memory accept / in-order response
//     inst_valid, inst, inst_pc           fetch-queue head towards decode
//     inst_ready                          decode consumes the head
interface proc_fetch_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  fetch_en;
  logic                  redir;
  logic [ADDR_WIDTH-1:0] redir_pc;
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_add;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  inst_valid;
  logic [DATA_WIDTH-1:0] inst;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic                  inst_ready;

  modport master (
    input  fetch_en, redir, redir_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_add, inst_valid, inst, inst_pc
  );

  modport slave (
    output fetch_en, redir, redir_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_add, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/proc_fetch_unit.sv
// proc_fetch_unit
//   Instruction-fetch stage. Issues word fetches to program memory over a
//   req/gnt + in-order rvalid handshake, buffers up to FQ_DEPTH PC-tagged
//   instructions in an in-order queue and hands them to decode with
//   valid/ready. A redirect restarts fetch at a new PC, empties the queue
//   and discards the responses of fetches still in flight.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  proc_fetch_unit_if.master (memory channel + decode hand-off)
module proc_fetch_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int PC_START   = 128,
  parameter int FQ_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  proc_fetch_unit_if.master  bus
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] PC_RST = ADDR_WIDTH'(PC_START);

  // Control state
  logic [ADDR_WIDTH-1:0] fetch_pc;     // next address to request
  logic [ADDR_WIDTH-1:0] resp_pc;      // PC tag for the next kept response
  logic [CNT_W-1:0]      outstanding;  // granted, response not yet seen
  logic [CNT_W-1:0]      drop_cnt;     // responses still owed to a redirect
  logic [CNT_W-1:0]      count;        // queued entries
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  // Queue storage (data only, never reset)
  logic [DATA_WIDTH-1:0] q_data [FQ_DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc   [FQ_DEPTH];

  logic            credit_ok;
  logic            req;
  logic            fire;
  logic            rsp;
  logic            push;
  logic            pop;
  logic            head_valid;
  logic [CNT_W:0]  occupancy;

  // Request / response decode (combinational from registered state)
  always_comb begin
    // Every slot is reserved at grant time, so queued + in-flight can never
    // exceed the queue size and a response always finds room.
    occupancy  = {1'b0, count} + {1'b0, outstanding};
    credit_ok  = occupancy < (CNT_W+1)'(FQ_DEPTH);
    req        = bus.fetch_en & ~bus.redir & credit_ok;
    fire       = req & bus.imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp        = bus.imem_rvalid & (outstanding != '0);
    head_valid = (count != '0);
    pop        = head_valid & bus.inst_ready;
    // A response arriving together with a redirect belongs to the old path.
    push       = rsp & (drop_cnt == '0) & ~bus.redir;
  end

  assign bus.imem_req   = req;
  assign bus.imem_add   = fetch_pc;
  assign bus.inst_valid = head_valid;
  assign bus.inst       = head_valid ? q_data[rd_ptr] : '0;
  assign bus.inst_pc    = head_valid ? q_pc[rd_ptr]   : '0;

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= PC_RST;
      resp_pc     <= PC_RST;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(fire) - CNT_W'(rsp);
      if (bus.redir) begin
        fetch_pc <= bus.redir_pc;
        resp_pc  <= bus.redir_pc;
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        // Everything still in flight belongs to the abandoned path; this
        // overwrites any earlier drop count, so the newest redirect wins.
        drop_cnt <= outstanding - CNT_W'(rsp);
      end else begin
        if (fire) begin
          fetch_pc <= fetch_pc + ADDR_WIDTH'(1);
        end
        if (rsp && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CNT_W'(1);
        end
        if (push) begin
          resp_pc <= resp_pc + ADDR_WIDTH'(1);
          wr_ptr  <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Queue write
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= bus.imem_rdata;
      q_pc[wr_ptr]   <= resp_pc;
    end
  end

  a_rvalid_expected: assert property (@(posedge clk) disable iff (rst)
    bus.imem_rvalid |-> (outstanding != '0))
    else $error("proc_fetch_unit: rvalid with no fetch outstanding");

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    push |-> ((count < CNT_W'(FQ_DEPTH)) || pop))
    else $error("proc_fetch_unit: push into a full queue");

endmodule

// File: tb/tb_proc_fetch_unit.sv
// tb_proc_fetch_unit
//   Bench for proc_fetch_unit. A memory responder with configurable grant
//   behaviour and random in-order latency feeds the DUT; a transaction-level
//   reference (queue of expected PCs, list of in-flight fetches tagged stale
//   on redirect) predicts request, address and queue-head outputs.
//   A second instance with PC_START=1022 covers address wrap.
module tb_proc_fetch_unit;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  proc_fetch_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  proc_fetch_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_w ();

  proc_fetch_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PC_START(128), .FQ_DEPTH(DEPTH))
    dut (.clk(clk), .rst(rst), .bus(bus.master));

  proc_fetch_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PC_START(1022), .FQ_DEPTH(DEPTH))
    dut_w (.clk(clk), .rst(rst), .bus(bus_w.master));

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
    bit            stale;
  } pend_t;

  int n_cmp = 0;
  int n_fail = 0;

  // responder / reference state
  pend_t         pend[$];
  logic [AW-1:0] fq[$];
  logic [AW-1:0] m_fetch_pc;
  int cyc = 0;
  int last_due = 0;
  int gnt_mode = 0;  // 0: always grant, 1: random, 2: never
  int lat_min = 1;
  int lat_max = 1;

  // per-cycle samples and predictions
  logic          s_req, s_valid, granted, popped;
  logic [AW-1:0] s_add, s_pc;
  logic [DW-1:0] s_inst;
  logic          m_req, m_valid;
  logic [AW-1:0] m_add, m_pc;
  logic [DW-1:0] m_inst;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {6'h2b, a, ~a, 6'h15};
  endfunction

  // One clock of the environment: memory side, sample, reference update.
  task automatic cycle();
    pend_t d;
    bit    got;
    int    due;
    got = 0;
    d = '{addr: '0, due: 0, stale: 1'b0};
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom;
    if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
      d = pend.pop_front();
      got = 1;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(d.addr);
    end
    case (gnt_mode)
      0:       bus.imem_gnt = 1'b1;
      1:       bus.imem_gnt = 1'($urandom_range(0, 1));
      default: bus.imem_gnt = 1'b0;
    endcase
    #1;
    s_req   = bus.imem_req;
    s_add   = bus.imem_add;
    s_valid = bus.inst_valid;
    s_pc    = bus.inst_pc;
    s_inst  = bus.inst;
    granted = s_req & bus.imem_gnt;
    popped  = s_valid & bus.inst_ready;
    m_req   = bus.fetch_en & ~bus.redir & ((fq.size() + pend.size() + int'(got)) < DEPTH);
    m_add   = m_fetch_pc;
    m_valid = (fq.size() != 0);
    m_pc    = m_valid ? fq[0] : '0;
    m_inst  = mem_word(m_pc);
    if (rst) begin
      fq.delete();
      pend.delete();
      m_fetch_pc = AW'(128);
      last_due = cyc;
    end else begin
      if (granted) begin
        due = cyc + $urandom_range(lat_min, lat_max);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend.push_back('{addr: m_fetch_pc, due: due, stale: 1'b0});
        m_fetch_pc = m_fetch_pc + AW'(1);
      end
      if (m_valid && bus.inst_ready) void'(fq.pop_front());
      if (bus.redir) begin
        fq.delete();
        foreach (pend[i]) pend[i].stale = 1'b1;
        m_fetch_pc = bus.redir_pc;
      end else if (got && !d.stale) begin
        fq.push_back(d.addr);
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.fetch_en = 1'b0;
    bus.redir = 1'b0;
    bus.redir_pc = '0;
    bus.inst_ready = 1'b0;
    gnt_mode = 0;
    lat_min = 1;
    lat_max = 1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    #1;
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", bus.imem_req); end
    n_cmp++; if (bus.imem_add !== AW'(128)) begin n_fail++; $display("FAIL reset_add got %0d want 128", bus.imem_add); end
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.inst_valid); end
    n_cmp++; if (bus.inst !== '0) begin n_fail++; $display("FAIL reset_inst got %h want 0", bus.inst); end
    n_cmp++; if (bus.inst_pc !== '0) begin n_fail++; $display("FAIL reset_pc got %0d want 0", bus.inst_pc); end
    n_cmp++; if (bus_w.imem_add !== AW'(1022)) begin n_fail++; $display("FAIL reset_add_w got %0d want 1022", bus_w.imem_add); end
  endtask

  task automatic test_stream();
    reset_dut();
    bus.fetch_en = 1'b1;
    bus.inst_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      n_cmp++; if (s_req !== 1'b1 || s_add !== AW'(128 + k)) begin
        n_fail++; $display("FAIL stream_req k=%0d got req=%b add=%0d want req=1 add=%0d", k, s_req, s_add, 128 + k);
      end
      if (k < 2) begin
        n_cmp++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid k=%0d got %b want 0", k, s_valid); end
      end else begin
        n_cmp++; if (s_valid !== 1'b1 || s_pc !== AW'(128 + k - 2) || s_inst !== mem_word(AW'(128 + k - 2))) begin
          n_fail++; $display("FAIL stream_head k=%0d got v=%b pc=%0d inst=%h want v=1 pc=%0d inst=%h",
                             k, s_valid, s_pc, s_inst, 128 + k - 2, mem_word(AW'(128 + k - 2)));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int grants, npop;
    logic [AW-1:0] first_add;
    bit seen;
    reset_dut();
    bus.fetch_en = 1'b1;
    grants = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (granted) grants++;
      if (s_valid) begin
        n_cmp++; if (s_pc !== AW'(128)) begin n_fail++; $display("FAIL bp_head_hold k=%0d got %0d want 128", k, s_pc); end
      end
    end
    n_cmp++; if (grants != 4) begin n_fail++; $display("FAIL bp_grants got %0d want 4", grants); end
    n_cmp++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_full got %b want 0", s_req); end
    bus.inst_ready = 1'b1;
    npop = 0;
    seen = 0;
    first_add = '0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (popped && npop < 4) begin
        n_cmp++; if (s_pc !== AW'(128 + npop)) begin n_fail++; $display("FAIL bp_drain n=%0d got %0d want %0d", npop, s_pc, 128 + npop); end
        npop++;
      end
      if (granted && !seen) begin seen = 1; first_add = s_add; end
    end
    n_cmp++; if (npop != 4) begin n_fail++; $display("FAIL bp_drain_count got %0d want 4", npop); end
    n_cmp++; if (!seen || first_add !== AW'(132)) begin n_fail++; $display("FAIL bp_resume got %0d (seen=%0d) want 132", first_add, seen); end
  endtask

  task automatic test_gnt_stall();
    int npop;
    reset_dut();
    bus.fetch_en = 1'b1;
    bus.inst_ready = 1'b1;
    gnt_mode = 2;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_cmp++; if (s_req !== 1'b1 || s_add !== AW'(128)) begin
        n_fail++; $display("FAIL stall_hold k=%0d got req=%b add=%0d want req=1 add=128", k, s_req, s_add);
      end
    end
    gnt_mode = 0;
    cycle();
    n_cmp++; if (!granted || s_add !== AW'(128)) begin n_fail++; $display("FAIL stall_grant got g=%b add=%0d want g=1 add=128", granted, s_add); end
    gnt_mode = 2;
    npop = 0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (k == 0) begin
        n_cmp++; if (s_add !== AW'(129)) begin n_fail++; $display("FAIL stall_next_add got %0d want 129", s_add); end
      end
      if (popped) begin
        npop++;
        n_cmp++; if (s_pc !== AW'(128)) begin n_fail++; $display("FAIL stall_pc got %0d want 128", s_pc); end
      end
    end
    n_cmp++; if (npop != 1) begin n_fail++; $display("FAIL stall_single got %0d want 1", npop); end
  endtask

  task automatic test_redirect();
    int npop;
    reset_dut();
    bus.fetch_en = 1'b1;
    bus.inst_ready = 1'b1;
    lat_min = 3;
    lat_max = 3;
    cycle();
    cycle();
    bus.redir = 1'b1;
    bus.redir_pc = AW'(40);
    cycle();
    n_cmp++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL redir_req got %b want 0", s_req); end
    bus.redir = 1'b0;
    cycle();
    n_cmp++; if (s_valid !== 1'b0 || s_add !== AW'(40)) begin
      n_fail++; $display("FAIL redir_after got v=%b add=%0d want v=0 add=40", s_valid, s_add);
    end
    npop = 0;
    for (int k = 0; k < 20 && npop < 2; k++) begin
      cycle();
      if (popped) begin
        n_cmp++; if (s_pc !== AW'(40 + npop)) begin n_fail++; $display("FAIL redir_pc n=%0d got %0d want %0d", npop, s_pc, 40 + npop); end
        npop++;
      end
    end
    n_cmp++; if (npop != 2) begin n_fail++; $display("FAIL redir_timeout got %0d pops want 2", npop); end
  endtask

  task automatic test_back_to_back();
    int npop;
    reset_dut();
    bus.fetch_en = 1'b1;
    bus.inst_ready = 1'b1;
    lat_min = 1;
    lat_max = 2;
    repeat (4) cycle();
    bus.redir = 1'b1;
    bus.redir_pc = AW'(200);
    cycle();
    bus.redir_pc = AW'(300);
    cycle();
    bus.redir = 1'b0;
    npop = 0;
    for (int k = 0; k < 30 && npop < 3; k++) begin
      cycle();
      n_cmp++; if (s_valid !== m_valid || (m_valid && s_pc !== m_pc)) begin
        n_fail++; $display("FAIL b2b_model k=%0d got v=%b pc=%0d want v=%b pc=%0d", k, s_valid, s_pc, m_valid, m_pc);
      end
      if (popped) begin
        n_cmp++; if (s_pc !== AW'(300 + npop)) begin n_fail++; $display("FAIL b2b_pc n=%0d got %0d want %0d", npop, s_pc, 300 + npop); end
        npop++;
      end
    end
    n_cmp++; if (npop != 3) begin n_fail++; $display("FAIL b2b_timeout got %0d pops want 3", npop); end
  endtask

  task automatic test_wrap();
    logic          rv;
    logic [AW-1:0] ra;
    logic [AW-1:0] e;
    rv = 1'b0;
    ra = '0;
    for (int k = 0; k < 8; k++) begin
      bus_w.fetch_en    = 1'b1;
      bus_w.inst_ready  = 1'b1;
      bus_w.imem_gnt    = 1'b1;
      bus_w.imem_rvalid = rv;
      bus_w.imem_rdata  = mem_word(ra);
      #1;
      if (k < 4) begin
        e = AW'(1022 + k);
        n_cmp++; if (bus_w.imem_req !== 1'b1 || bus_w.imem_add !== e) begin
          n_fail++; $display("FAIL wrap_add k=%0d got req=%b add=%0d want req=1 add=%0d", k, bus_w.imem_req, bus_w.imem_add, e);
        end
      end
      if (k >= 2 && k < 6) begin
        e = AW'(1022 + k - 2);
        n_cmp++; if (bus_w.inst_valid !== 1'b1 || bus_w.inst_pc !== e || bus_w.inst !== mem_word(e)) begin
          n_fail++; $display("FAIL wrap_pc k=%0d got v=%b pc=%0d inst=%h want v=1 pc=%0d inst=%h",
                             k, bus_w.inst_valid, bus_w.inst_pc, bus_w.inst, e, mem_word(e));
        end
      end
      rv = bus_w.imem_req & bus_w.imem_gnt;
      ra = bus_w.imem_add;
      @(posedge clk);
      @(negedge clk);
    end
    bus_w.fetch_en = 1'b0;
    bus_w.imem_rvalid = 1'b0;
    bus_w.imem_gnt = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int npop;
    reset_dut();
    bus.fetch_en = 1'b1;
    repeat (4) cycle();
    n_cmp++; if (s_valid !== 1'b1 || s_pc !== AW'(128)) begin n_fail++; $display("FAIL mid_pre got v=%b pc=%0d want v=1 pc=128", s_valid, s_pc); end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.inst_valid !== 1'b0 || bus.imem_add !== AW'(128) || bus.inst !== '0) begin
      n_fail++; $display("FAIL mid_reset got v=%b add=%0d inst=%h want v=0 add=128 inst=0", bus.inst_valid, bus.imem_add, bus.inst);
    end
    bus.inst_ready = 1'b1;
    npop = 0;
    for (int k = 0; k < 15 && npop < 3; k++) begin
      cycle();
      if (popped) begin
        n_cmp++; if (s_pc !== AW'(128 + npop) || s_inst !== mem_word(AW'(128 + npop))) begin
          n_fail++; $display("FAIL mid_restart n=%0d got pc=%0d want %0d", npop, s_pc, 128 + npop);
        end
        npop++;
      end
    end
    n_cmp++; if (npop != 3) begin n_fail++; $display("FAIL mid_timeout got %0d pops want 3", npop); end
  endtask

  task automatic test_random();
    reset_dut();
    gnt_mode = 1;
    lat_min = 1;
    lat_max = 4;
    for (int k = 0; k < 3000; k++) begin
      bus.fetch_en   = ($urandom_range(0, 9) != 0);
      bus.inst_ready = ($urandom_range(0, 3) != 0);
      bus.redir      = ($urandom_range(0, 39) == 0);
      bus.redir_pc   = AW'($urandom);
      cycle();
      n_cmp++; if (s_req !== m_req || s_add !== m_add) begin
        n_fail++; if (n_fail < 20) $display("FAIL rand_req k=%0d got req=%b add=%0d want req=%b add=%0d", k, s_req, s_add, m_req, m_add);
      end
      n_cmp++; if (s_valid !== m_valid) begin
        n_fail++; if (n_fail < 20) $display("FAIL rand_valid k=%0d got %b want %b", k, s_valid, m_valid);
      end
      if (m_valid) begin
        n_cmp++; if (s_pc !== m_pc || s_inst !== m_inst) begin
          n_fail++; if (n_fail < 20) $display("FAIL rand_head k=%0d got pc=%0d inst=%h want pc=%0d inst=%h", k, s_pc, s_inst, m_pc, m_inst);
        end
      end
    end
    bus.redir = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.fetch_en = 1'b0; bus.redir = 1'b0; bus.redir_pc = '0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.inst_ready = 1'b0;
    bus_w.fetch_en = 1'b0; bus_w.redir = 1'b0; bus_w.redir_pc = '0;
    bus_w.imem_gnt = 1'b0; bus_w.imem_rvalid = 1'b0; bus_w.imem_rdata = '0; bus_w.inst_ready = 1'b0;
    m_fetch_pc = AW'(128);
    @(negedge clk);
    test_reset();
    test_wrap();
    test_stream();
    test_backpressure();
    test_gnt_stall();
    test_redirect();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
